// File: rtl/console_pkg.sv
// console_pkg -- shared definitions for the text console.
// Used by the console writer and by the VRAM reader side, so the screen
// geometry, blank code, control codes and FSM encoding live in one place.
//   SCREEN_W / SCREEN_H : text grid size (characters x rows)
//   BLANK_CODE          : code stored in cleared cells
//   CODE_CR/LF/BS/FF    : control codes understood by the writer
//   state_t             : writer FSM encoding
//   row_base()          : VRAM address of column 0 of a row
package console_pkg;

   localparam int unsigned SCREEN_W    = 40;
   localparam int unsigned SCREEN_H    = 30;
   localparam int unsigned VRAM_ADDR_W = 11;

   localparam logic [7:0] BLANK_CODE = 8'h20;
   localparam logic [7:0] CODE_CR    = 8'h0D;
   localparam logic [7:0] CODE_LF    = 8'h0A;
   localparam logic [7:0] CODE_BS    = 8'h08;
   localparam logic [7:0] CODE_FF    = 8'h0C;

   typedef enum logic [1:0] {
      CLEAR_ALL  = 2'd0,
      IDLE       = 2'd1,
      WRITE      = 2'd2,
      CLEAR_LINE = 2'd3
   } state_t;

   // Address of the first cell of a row; unsigned 11-bit arithmetic.
   function automatic logic [10:0] row_base(input logic [4:0] row,
                                            input int unsigned width);
      return 11'(row) * 11'(width);
   endfunction

endpackage

// File: rtl/console_writer_if.sv
// console_writer_if -- character input handshake plus VRAM write port and
// cursor position of the console writer.
//   char_i, char_valid, char_ready : producer -> writer valid/ready handshake
//   addr_vram_w, data_vram_w, we_vram : writer -> video RAM write port
//   cursor_x, cursor_y : current cursor position
// Modports: slave = the console writer, master = the character producer.
interface console_writer_if;

   logic [7:0]  char_i;
   logic        char_valid;
   logic        char_ready;
   logic [10:0] addr_vram_w;
   logic [7:0]  data_vram_w;
   logic        we_vram;
   logic [5:0]  cursor_x;
   logic [4:0]  cursor_y;

   modport slave (
      input  char_i, char_valid,
      output char_ready, addr_vram_w, data_vram_w, we_vram, cursor_x, cursor_y
   );

   modport master (
      output char_i, char_valid,
      input  char_ready, addr_vram_w, data_vram_w, we_vram, cursor_x, cursor_y
   );

endinterface

// File: rtl/console_writer.sv
// console_writer -- turns a stream of character codes into VRAM writes for a
// screenW x screenH text screen, handling CR, LF, BS, FF, line wrap, wrap from
// the last row to row 0 and clearing of each newly entered line.
//   px_clk  : pixel clock, all logic on its rising edge
//   reset   : synchronous active-high reset, restarts the full-screen clear
//   bus     : console_writer_if.slave (char handshake, VRAM write, cursor)
// All outputs are registered; a write appears the cycle after acceptance.
module console_writer
   import console_pkg::*;
#(
   parameter int unsigned screenW = SCREEN_W,
   parameter int unsigned screenH = SCREEN_H,
   parameter logic [7:0]  BLANK   = BLANK_CODE
) (
   input logic               px_clk,
   input logic               reset,
   console_writer_if.slave   bus
);

   localparam logic [10:0] CELLS     = 11'(screenW * screenH);
   localparam logic [10:0] ROW_CELLS = 11'(screenW);
   localparam logic [5:0]  X_LAST    = 6'(screenW - 1);
   localparam logic [4:0]  Y_LAST    = 5'(screenH - 1);

   state_t      state;
   logic [10:0] clr_cnt;
   logic [5:0]  cur_x;
   logic [4:0]  cur_y;
   logic        bs_pend;
   logic        ready_r;
   logic        we_r;
   logic [10:0] addr_r;
   logic [7:0]  data_r;

   logic [4:0]  next_y;
   logic [10:0] cur_base;
   logic [10:0] next_base;
   logic        accept;
   logic        printable;

   always_comb begin
      next_y    = (cur_y == Y_LAST) ? 5'd0 : cur_y + 5'd1;
      cur_base  = row_base(cur_y, screenW);
      next_base = row_base(next_y, screenW);
      accept    = bus.char_valid & ready_r;
      printable = (bus.char_i >= 8'h20) && (bus.char_i <= 8'h7E);
   end

   always_ff @(posedge px_clk) begin
      if (reset) begin
         state   <= CLEAR_ALL;
         clr_cnt <= '0;
         cur_x   <= '0;
         cur_y   <= '0;
         bs_pend <= 1'b0;
         ready_r <= 1'b0;
         we_r    <= 1'b0;
         addr_r  <= '0;
         data_r  <= BLANK;
      end else begin
         case (state)
            // One leading cycle with no write, then one cell per cycle; the
            // extra terminal count keeps we_vram low once IDLE is entered.
            CLEAR_ALL: begin
               if (clr_cnt == CELLS) begin
                  state   <= IDLE;
                  ready_r <= 1'b1;
                  we_r    <= 1'b0;
                  cur_x   <= '0;
                  cur_y   <= '0;
               end else begin
                  we_r    <= 1'b1;
                  addr_r  <= clr_cnt;
                  data_r  <= BLANK;
                  clr_cnt <= clr_cnt + 11'd1;
               end
            end

            IDLE: begin
               we_r <= 1'b0;
               if (accept) begin
                  if (printable) begin
                     state   <= WRITE;
                     ready_r <= 1'b0;
                     we_r    <= 1'b1;
                     addr_r  <= cur_base + {5'd0, cur_x};
                     data_r  <= bus.char_i;
                     bs_pend <= 1'b0;
                  end else if (bus.char_i == CODE_CR) begin
                     cur_x <= '0;
                  end else if (bus.char_i == CODE_LF) begin
                     // New line: step the row and emit column 0 of the clear now.
                     cur_x   <= '0;
                     cur_y   <= next_y;
                     state   <= CLEAR_LINE;
                     ready_r <= 1'b0;
                     we_r    <= 1'b1;
                     addr_r  <= next_base;
                     data_r  <= BLANK;
                     clr_cnt <= 11'd1;
                  end else if (bus.char_i == CODE_BS) begin
                     if (cur_x != 6'd0) begin
                        // Cursor moves back when the write completes.
                        state   <= WRITE;
                        ready_r <= 1'b0;
                        we_r    <= 1'b1;
                        addr_r  <= cur_base + {5'd0, cur_x} - 11'd1;
                        data_r  <= BLANK;
                        bs_pend <= 1'b1;
                     end
                  end else if (bus.char_i == CODE_FF) begin
                     state   <= CLEAR_ALL;
                     ready_r <= 1'b0;
                     clr_cnt <= '0;
                  end
               end
            end

            WRITE: begin
               if (bs_pend) begin
                  cur_x   <= cur_x - 6'd1;
                  state   <= IDLE;
                  ready_r <= 1'b1;
                  we_r    <= 1'b0;
               end else if (cur_x != X_LAST) begin
                  cur_x   <= cur_x + 6'd1;
                  state   <= IDLE;
                  ready_r <= 1'b1;
                  we_r    <= 1'b0;
               end else begin
                  // Wrapped past the last column: same new-line step as LF.
                  cur_x   <= '0;
                  cur_y   <= next_y;
                  state   <= CLEAR_LINE;
                  we_r    <= 1'b1;
                  addr_r  <= next_base;
                  data_r  <= BLANK;
                  clr_cnt <= 11'd1;
               end
            end

            // cur_y already holds the new row, so cur_base addresses it.
            CLEAR_LINE: begin
               if (clr_cnt == ROW_CELLS) begin
                  state   <= IDLE;
                  ready_r <= 1'b1;
                  we_r    <= 1'b0;
               end else begin
                  we_r    <= 1'b1;
                  addr_r  <= cur_base + clr_cnt;
                  data_r  <= BLANK;
                  clr_cnt <= clr_cnt + 11'd1;
               end
            end

            default: begin
               state   <= CLEAR_ALL;
               clr_cnt <= '0;
               ready_r <= 1'b0;
               we_r    <= 1'b0;
            end
         endcase
      end
   end

   assign bus.char_ready  = ready_r;
   assign bus.we_vram     = we_r;
   assign bus.addr_vram_w = addr_r;
   assign bus.data_vram_w = data_r;
   assign bus.cursor_x    = cur_x;
   assign bus.cursor_y    = cur_y;

endmodule

// File: tb/tb_console_writer.sv
// tb_console_writer -- directed bench for console_writer at default geometry
// (40 x 30, blank 8'h20). Inputs change and outputs are sampled on the
// falling edge of px_clk.
module tb_console_writer;
   import console_pkg::*;

   logic px_clk = 1'b0;
   logic reset  = 1'b1;

   console_writer_if bus ();

   console_writer dut (
      .px_clk (px_clk),
      .reset  (reset),
      .bus    (bus)
   );

   always #5 px_clk = ~px_clk;

   int unsigned cyc = 0;
   always @(posedge px_clk) cyc <= cyc + 1;

   int n_vec = 0;
   int n_err = 0;

   logic [10:0] wa[$];
   logic [7:0]  wd[$];
   logic        coll_to;

   initial begin
      #5ms;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(negedge px_clk);
   endtask

   // Offer one code; returns at the falling edge right after acceptance.
   task automatic send(input logic [7:0] c, output int unsigned acc_cyc);
      int n = 0;
      while (bus.char_ready !== 1'b1 && n < 2000) begin
         tick();
         n++;
      end
      bus.char_i     = c;
      bus.char_valid = 1'b1;
      tick();
      acc_cyc        = cyc;
      bus.char_valid = 1'b0;
      bus.char_i     = 8'h00;
   endtask

   // Record every VRAM write from the current cycle until char_ready is 1.
   task automatic collect(input int bound);
      int n = 0;
      wa.delete();
      wd.delete();
      coll_to = 1'b0;
      while (1) begin
         if (bus.we_vram === 1'b1) begin
            wa.push_back(bus.addr_vram_w);
            wd.push_back(bus.data_vram_w);
         end
         if (bus.char_ready === 1'b1) break;
         if (n >= bound) begin
            coll_to = 1'b1;
            break;
         end
         tick();
         n++;
      end
   endtask

   task automatic test_reset();
      int bad;
      reset          = 1'b1;
      bus.char_valid = 1'b0;
      bus.char_i     = 8'h00;
      tick();
      tick();
      n_vec++; if (bus.we_vram !== 1'b0) begin n_err++; $display("FAIL rst_we: got %b want 0", bus.we_vram); end
      n_vec++; if (bus.char_ready !== 1'b0) begin n_err++; $display("FAIL rst_ready: got %b want 0", bus.char_ready); end
      n_vec++; if (bus.addr_vram_w !== 11'd0) begin n_err++; $display("FAIL rst_addr: got %0d want 0", bus.addr_vram_w); end
      n_vec++; if (bus.data_vram_w !== 8'h20) begin n_err++; $display("FAIL rst_data: got %h want 20", bus.data_vram_w); end
      n_vec++; if (bus.cursor_x !== 6'd0 || bus.cursor_y !== 5'd0) begin n_err++; $display("FAIL rst_cursor: got (%0d,%0d) want (0,0)", bus.cursor_x, bus.cursor_y); end
      reset = 1'b0;
      tick();
      collect(1300);
      bad = -1;
      foreach (wa[i]) if ((wa[i] !== 11'(i) || wd[i] !== 8'h20) && bad < 0) bad = i;
      n_vec++; if (coll_to !== 1'b0 || wa.size() != 1200) begin n_err++; $display("FAIL clr_count: got %0d writes timeout=%b want 1200", wa.size(), coll_to); end
      n_vec++; if (bad >= 0) begin n_err++; $display("FAIL clr_seq: index %0d got addr %0d data %h want addr %0d data 20", bad, wa[bad], wd[bad], bad); end
      n_vec++; if (bus.cursor_x !== 6'd0 || bus.cursor_y !== 5'd0) begin n_err++; $display("FAIL clr_cursor: got (%0d,%0d) want (0,0)", bus.cursor_x, bus.cursor_y); end
      n_vec++; if (bus.we_vram !== 1'b0) begin n_err++; $display("FAIL idle_we: got %b want 0", bus.we_vram); end
   endtask

   task automatic test_print_ab();
      int unsigned c0, c1;
      send(8'h41, c0);
      n_vec++; if (bus.we_vram !== 1'b1 || bus.addr_vram_w !== 11'd0 || bus.data_vram_w !== 8'h41) begin n_err++; $display("FAIL write_A: got we=%b addr %0d data %h want we=1 addr 0 data 41", bus.we_vram, bus.addr_vram_w, bus.data_vram_w); end
      n_vec++; if (bus.char_ready !== 1'b0) begin n_err++; $display("FAIL ready_in_write: got %b want 0", bus.char_ready); end
      collect(10);
      n_vec++; if (bus.cursor_x !== 6'd1) begin n_err++; $display("FAIL cursor_after_A: got %0d want 1", bus.cursor_x); end
      send(8'h42, c1);
      n_vec++; if (bus.we_vram !== 1'b1 || bus.addr_vram_w !== 11'd1 || bus.data_vram_w !== 8'h42) begin n_err++; $display("FAIL write_B: got we=%b addr %0d data %h want we=1 addr 1 data 42", bus.we_vram, bus.addr_vram_w, bus.data_vram_w); end
      n_vec++; if (c1 - c0 != 2) begin n_err++; $display("FAIL throughput: got %0d cycles between accepts want 2", c1 - c0); end
      collect(10);
      n_vec++; if (bus.cursor_x !== 6'd2 || bus.cursor_y !== 5'd0) begin n_err++; $display("FAIL cursor_after_B: got (%0d,%0d) want (2,0)", bus.cursor_x, bus.cursor_y); end
   endtask

   task automatic test_line_wrap();
      int unsigned c;
      int bad_char, bad_clr;
      send(CODE_CR, c);
      collect(10);
      n_vec++; if (wa.size() != 0 || bus.cursor_x !== 6'd0 || bus.cursor_y !== 5'd0) begin n_err++; $display("FAIL cr: got %0d writes cursor (%0d,%0d) want 0 writes (0,0)", wa.size(), bus.cursor_x, bus.cursor_y); end
      bad_char = -1;
      for (int i = 0; i < 39; i++) begin
         send(8'h78, c);
         if ((bus.we_vram !== 1'b1 || bus.addr_vram_w !== 11'(i) || bus.data_vram_w !== 8'h78) && bad_char < 0) bad_char = i;
         collect(10);
      end
      n_vec++; if (bad_char >= 0) begin n_err++; $display("FAIL row_chars: char %0d not written at addr %0d", bad_char, bad_char); end
      send(8'h78, c);
      collect(100);
      n_vec++; if (wa.size() != 41) begin n_err++; $display("FAIL wrap_count: got %0d writes want 41", wa.size()); end
      else begin
         n_vec++; if (wa[0] !== 11'd39 || wd[0] !== 8'h78) begin n_err++; $display("FAIL wrap_last: got addr %0d data %h want addr 39 data 78", wa[0], wd[0]); end
         bad_clr = -1;
         for (int i = 1; i < 41; i++) if ((wa[i] !== 11'(39 + i) || wd[i] !== 8'h20) && bad_clr < 0) bad_clr = i;
         n_vec++; if (bad_clr >= 0) begin n_err++; $display("FAIL wrap_clear: index %0d got addr %0d data %h want addr %0d data 20", bad_clr, wa[bad_clr], wd[bad_clr], 39 + bad_clr); end
      end
      n_vec++; if (bus.cursor_x !== 6'd0 || bus.cursor_y !== 5'd1) begin n_err++; $display("FAIL wrap_cursor: got (%0d,%0d) want (0,1)", bus.cursor_x, bus.cursor_y); end
   endtask

   task automatic test_lf_bottom();
      int unsigned c;
      int bad_lf, bad;
      bad_lf = -1;
      for (int i = 0; i < 28; i++) begin
         send(CODE_LF, c);
         collect(100);
         if ((wa.size() != 40 || wa[0] !== 11'((i + 2) * 40)) && bad_lf < 0) bad_lf = i;
      end
      n_vec++; if (bad_lf >= 0) begin n_err++; $display("FAIL lf_steps: LF %0d did not clear row %0d", bad_lf, bad_lf + 2); end
      for (int i = 0; i < 5; i++) begin
         send(8'h61, c);
         collect(10);
      end
      n_vec++; if (bus.cursor_x !== 6'd5 || bus.cursor_y !== 5'd29) begin n_err++; $display("FAIL pos_5_29: got (%0d,%0d) want (5,29)", bus.cursor_x, bus.cursor_y); end
      send(CODE_LF, c);
      collect(100);
      bad = -1;
      foreach (wa[i]) if ((wa[i] !== 11'(i) || wd[i] !== 8'h20) && bad < 0) bad = i;
      n_vec++; if (wa.size() != 40 || bad >= 0) begin n_err++; $display("FAIL lf_wrap_clear: got %0d writes first bad %0d want 40 writes addrs 0..39", wa.size(), bad); end
      n_vec++; if (bus.cursor_x !== 6'd0 || bus.cursor_y !== 5'd0) begin n_err++; $display("FAIL lf_wrap_cursor: got (%0d,%0d) want (0,0)", bus.cursor_x, bus.cursor_y); end
      send(CODE_BS, c);
      n_vec++; if (bus.we_vram !== 1'b0 || bus.char_ready !== 1'b1) begin n_err++; $display("FAIL bs_at_0: got we=%b ready=%b want we=0 ready=1", bus.we_vram, bus.char_ready); end
      n_vec++; if (bus.cursor_x !== 6'd0 || bus.cursor_y !== 5'd0) begin n_err++; $display("FAIL bs_at_0_cursor: got (%0d,%0d) want (0,0)", bus.cursor_x, bus.cursor_y); end
   endtask

   task automatic test_bs_and_ignored();
      int unsigned c;
      send(CODE_LF, c); collect(100);
      send(CODE_LF, c); collect(100);
      send(8'h61, c); collect(10);
      send(8'h62, c); collect(10);
      send(8'h63, c); collect(10);
      n_vec++; if (bus.cursor_x !== 6'd3 || bus.cursor_y !== 5'd2) begin n_err++; $display("FAIL pos_3_2: got (%0d,%0d) want (3,2)", bus.cursor_x, bus.cursor_y); end
      send(CODE_BS, c);
      n_vec++; if (bus.we_vram !== 1'b1 || bus.addr_vram_w !== 11'd82 || bus.data_vram_w !== 8'h20) begin n_err++; $display("FAIL bs_write: got we=%b addr %0d data %h want we=1 addr 82 data 20", bus.we_vram, bus.addr_vram_w, bus.data_vram_w); end
      collect(10);
      n_vec++; if (wa.size() != 1 || bus.cursor_x !== 6'd2 || bus.cursor_y !== 5'd2) begin n_err++; $display("FAIL bs_cursor: got %0d writes cursor (%0d,%0d) want 1 write (2,2)", wa.size(), bus.cursor_x, bus.cursor_y); end
      send(8'h07, c);
      n_vec++; if (bus.we_vram !== 1'b0 || bus.char_ready !== 1'b1) begin n_err++; $display("FAIL bel_ignored: got we=%b ready=%b want we=0 ready=1", bus.we_vram, bus.char_ready); end
      n_vec++; if (bus.cursor_x !== 6'd2 || bus.cursor_y !== 5'd2) begin n_err++; $display("FAIL bel_cursor: got (%0d,%0d) want (2,2)", bus.cursor_x, bus.cursor_y); end
      send(CODE_CR, c);
      n_vec++; if (bus.we_vram !== 1'b0 || bus.cursor_x !== 6'd0 || bus.cursor_y !== 5'd2) begin n_err++; $display("FAIL cr_mid: got we=%b cursor (%0d,%0d) want we=0 (0,2)", bus.we_vram, bus.cursor_x, bus.cursor_y); end
   endtask

   task automatic test_form_feed();
      int unsigned c;
      int bad;
      send(CODE_FF, c);
      n_vec++; if (bus.char_ready !== 1'b0 || bus.we_vram !== 1'b0) begin n_err++; $display("FAIL ff_entry: got ready=%b we=%b want ready=0 we=0", bus.char_ready, bus.we_vram); end
      collect(1300);
      bad = -1;
      foreach (wa[i]) if ((wa[i] !== 11'(i) || wd[i] !== 8'h20) && bad < 0) bad = i;
      n_vec++; if (wa.size() != 1200 || bad >= 0) begin n_err++; $display("FAIL ff_clear: got %0d writes first bad %0d want 1200 writes addrs 0..1199", wa.size(), bad); end
      n_vec++; if (bus.cursor_x !== 6'd0 || bus.cursor_y !== 5'd0) begin n_err++; $display("FAIL ff_cursor: got (%0d,%0d) want (0,0)", bus.cursor_x, bus.cursor_y); end
   endtask

   task automatic test_reset_mid_line();
      int unsigned c;
      int n, bad;
      send(CODE_LF, c);
      n = 0;
      while (!(bus.we_vram === 1'b1 && bus.addr_vram_w === 11'd57) && n < 60) begin
         tick();
         n++;
      end
      n_vec++; if (n >= 60) begin n_err++; $display("FAIL reach_col17: got addr %0d want 57", bus.addr_vram_w); end
      reset = 1'b1;
      tick();
      n_vec++; if (bus.we_vram !== 1'b0 || bus.char_ready !== 1'b0 || bus.addr_vram_w !== 11'd0 || bus.data_vram_w !== 8'h20) begin n_err++; $display("FAIL mid_rst_out: got we=%b ready=%b addr %0d data %h want 0 0 0 20", bus.we_vram, bus.char_ready, bus.addr_vram_w, bus.data_vram_w); end
      n_vec++; if (bus.cursor_x !== 6'd0 || bus.cursor_y !== 5'd0) begin n_err++; $display("FAIL mid_rst_cursor: got (%0d,%0d) want (0,0)", bus.cursor_x, bus.cursor_y); end
      reset = 1'b0;
      tick();
      collect(1300);
      bad = -1;
      foreach (wa[i]) if ((wa[i] !== 11'(i) || wd[i] !== 8'h20) && bad < 0) bad = i;
      n_vec++; if (wa.size() != 1200 || bad >= 0) begin n_err++; $display("FAIL mid_rst_clear: got %0d writes first bad %0d want 1200 writes addrs 0..1199", wa.size(), bad); end
   endtask

   initial begin
      bus.char_i     = 8'h00;
      bus.char_valid = 1'b0;
      test_reset();
      test_print_ab();
      test_line_wrap();
      test_lf_bottom();
      test_bs_and_ignored();
      test_form_feed();
      test_reset_mid_line();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/console_writer.md
CONSOLE_WRITER -- requirements
Module: console_writer

Interface
REQ-001 Parameter screenW, default 40, characters per text row.
REQ-002 Parameter screenH, default 30, text rows per screen.
REQ-003 Parameter BLANK, default 8'h20, code written to cleared cells.
REQ-004 px_clk  input  1  pixel clock; the single clock, all logic on its rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 char_i  input  8  ASCII code offered by the producer.
REQ-007 char_valid  input  1  char_i holds a valid code.
REQ-008 char_ready  output  1  block accepts char_i this cycle.
REQ-009 addr_vram_w  output  11  video RAM write address, row*screenW+col.
REQ-010 data_vram_w  output  8  video RAM write data.
REQ-011 we_vram  output  1  video RAM write strobe, one cell per cycle.
REQ-012 cursor_x  output  6  current cursor column, 0..screenW-1.
REQ-013 cursor_y  output  5  current cursor row, 0..screenH-1.

Function
REQ-014 A transfer occurs on a cycle where char_valid and char_ready are both 1; char_ready is 1 only in state IDLE.
REQ-015 States: CLEAR_ALL, IDLE, WRITE, CLEAR_LINE.
REQ-016 CLEAR_ALL writes BLANK to addresses 0..screenW*screenH-1 (0..1199 at defaults), one per cycle, ascending, then goes to IDLE with cursor at (0,0).
REQ-017 Printable code (8'h20..8'h7E) accepted: next cycle is WRITE with we_vram=1, addr_vram_w=cursor_y*screenW+cursor_x, data_vram_w=code; cursor then advances.
REQ-018 Advance: cursor_x<screenW-1 -> cursor_x+1; else cursor_x=0 and a new-line step follows.
REQ-019 8'h0D (CR): cursor_x=0, no write, back to IDLE in one cycle.
REQ-020 8'h0A (LF): cursor_x=0 followed by a new-line step.
REQ-021 New-line step: cursor_y=(cursor_y==screenH-1)?0:cursor_y+1, then CLEAR_LINE writes BLANK to all screenW cells of the new row, ascending columns, then IDLE.
REQ-022 8'h08 (BS): if cursor_x>0, cursor_x-1 and WRITE BLANK at the new position; if cursor_x==0, no change, no write.
REQ-023 8'h0C (FF): enter CLEAR_ALL; cursor ends at (0,0).
REQ-024 Any other code is consumed and ignored: no write, cursor unchanged, IDLE on the next cycle.
REQ-025 Sustained throughput is one printable character per 2 cycles, excluding line clears.
REQ-026 Latency from accept to we_vram is exactly 1 cycle; address and data are registered outputs.
REQ-027 we_vram=0 in IDLE; addr_vram_w and data_vram_w are don't-care when we_vram=0.
REQ-028 cursor_x and cursor_y update on the cycle the corresponding write or step completes and are stable in IDLE.
REQ-029 Address arithmetic is 11-bit unsigned; at defaults the maximum is 1199, with no overflow.

Reset
REQ-030 On reset: state=CLEAR_ALL, clear counter=0, cursor=(0,0), char_ready=0, we_vram=0, addr_vram_w=0, data_vram_w=BLANK.
REQ-031 Reset asserted mid-operation (any state) aborts it and restarts the full clear from address 0 on the next cycle; a pending character is discarded.

Structure
REQ-032 screenW, screenH, BLANK, control codes (CR, LF, BS, FF) and the state encoding are defined in shared package console_pkg, which is also used by the VRAM reader side.
REQ-033 No sub-module; the single FSM with its clear counter and cursor registers is implemented in console_writer.

Verification
REQ-034 Release reset, hold char_valid=0 -> exactly 1200 writes of 8'h20 to addresses 0..1199 in order, then char_ready=1, cursor (0,0).
REQ-035 After clear, send 'A','B' -> writes (0,8'h41) and (1,8'h42), each 1 cycle after accept; cursor_x=2.
REQ-036 Send 40 'x' from (0,0) -> last write at addr 39, cursor (0,1), then 40 BLANK writes to addrs 40..79 before char_ready returns.
REQ-037 Cursor at (5,29), send LF -> cursor (0,0), BLANK writes to addrs 0..39; send BS at x=0 -> no write, cursor unchanged.
REQ-038 Cursor at (3,2), send BS -> write BLANK at addr 82, cursor (2,2); send 8'h07 -> no write, char_ready back 1 cycle later.
REQ-039 Assert reset during CLEAR_LINE at column 17 -> next cycle state CLEAR_ALL, write sequence restarts at addr 0, cursor (0,0).
